// File: rtl/mod_counter_pkg.sv
// rtl/mod_counter_pkg.sv - shared FSM encoding and default sizing for the up/down counter
//
// Purpose : holds the RUN/HALT state encoding and the default WIDTH/MODULUS
//           constants used by mod_updown_counter and anything cascading it.
// Ports   : none (package)
package mod_counter_pkg;

  localparam int DEFAULT_WIDTH   = 4;
  localparam int DEFAULT_MODULUS = 10;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } state_e;

endpackage : mod_counter_pkg

// File: rtl/mod_updown_counter.sv
// rtl/mod_updown_counter.sv - modulo-N up/down counter with load, clear and one-shot halt
//
// Purpose : counts 0..MODULUS-1 up or down. Free-run mode wraps and pulses
//           wrap; one-shot mode parks at the terminal value and raises done
//           until the next clr or load.
// Ports   :
//   clk      in   sole clock, rising edge
//   rst      in   synchronous reset, active low
//   en       in   count enable
//   up_dn    in   direction, 1 = up, 0 = down
//   clr      in   synchronous clear to 0 (beats load)
//   load     in   synchronous parallel load strobe
//   load_val in   [WIDTH] load value, saturated to MODULUS-1
//   oneshot  in   0 = free-run wrap, 1 = halt at terminal
//   count    out  [WIDTH] registered count
//   tc       out  combinational terminal-count flag for cascading
//   wrap     out  registered one-cycle wrap pulse
//   done     out  registered one-shot halted flag
module mod_updown_counter
  import mod_counter_pkg::*;
#(
  parameter int WIDTH   = DEFAULT_WIDTH,
  parameter int MODULUS = DEFAULT_MODULUS
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up_dn,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             oneshot,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             wrap,
  output logic             done
);

  if (MODULUS < 2 || MODULUS > (1 << WIDTH)) begin : g_bad_modulus
    $error("mod_updown_counter: MODULUS must be in 2..2**WIDTH");
  end

  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);
  // One extra bit so MODULUS == 2**WIDTH is representable in the compare.
  localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MODULUS);

  logic [WIDTH-1:0] count_q, count_d;
  state_e           state_q, state_d;
  logic             wrap_q, wrap_d;
  logic             done_q, done_d;

  logic [WIDTH-1:0] terminal;
  logic             at_term;
  logic [WIDTH-1:0] load_sat;

  assign terminal = up_dn ? MAX_VAL : '0;
  assign at_term  = (count_q == terminal);
  assign load_sat = ({1'b0, load_val} >= MOD_EXT) ? MAX_VAL : load_val;

  // Direction is sampled at the edge, so an up_dn change only affects the
  // next enabled step and the terminal it compares against.
  assign tc = en && at_term && (state_q == RUN);

  always_comb begin
    count_d = count_q;
    state_d = state_q;
    wrap_d  = 1'b0;
    done_d  = done_q;
    if (clr) begin
      count_d = '0;
      state_d = RUN;
      done_d  = 1'b0;
    end else if (load) begin
      // Loading terminal does not halt here; halting needs an enabled edge.
      count_d = load_sat;
      state_d = RUN;
      done_d  = 1'b0;
    end else if (en && state_q == RUN) begin
      if (at_term) begin
        if (oneshot) begin
          state_d = HALT;
          done_d  = 1'b1;
        end else begin
          count_d = up_dn ? '0 : MAX_VAL;
          wrap_d  = 1'b1;
        end
      end else begin
        count_d = up_dn ? count_q + WIDTH'(1) : count_q - WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      count_q <= '0;
      state_q <= RUN;
      wrap_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      state_q <= state_d;
      wrap_q  <= wrap_d;
      done_q  <= done_d;
    end
  end

  assign count = count_q;
  assign wrap  = wrap_q;
  assign done  = done_q;

endmodule : mod_updown_counter
